// File: rtl/timer_counter_mc.sv
// Multi-channel down-counter timer behind the CS_N/RD_N/WR_N peripheral bus.
// All channels share one prescaler tick; one-shot channels stop at expiry, periodic ones reload.
`timescale 1ns/1ps
module timer_counter_mc #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CS_N,
  input  logic              RD_N,
  input  logic              WR_N,
  input  logic [11:0]       Addr,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              Intr,
  output logic [NUM_CH-1:0] Intr_vec
);

  logic               wr_en;
  logic               presc_sel;
  logic               irq_sel;
  logic               tick;
  logic [NUM_CH-1:0]  ch_sel;
  logic [NUM_CH-1:0]  en_v, mode_v, ie_v, pend_v;
  logic [WIDTH-1:0]   load_v  [NUM_CH];
  logic [WIDTH-1:0]   count_v [NUM_CH];
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic [NUM_CH-1:0]  intr_vec_q, intr_vec_d;
  logic               intr_q, intr_d;
  logic [31:0]        rdata;
  logic               unused_bits;

  assign wr_en     = !CS_N && !WR_N;
  assign presc_sel = (Addr[11:2] == 10'h040);
  assign irq_sel   = (Addr[11:2] == 10'h041);
  assign tick      = (pcnt_q == presc_q);
  // Byte lanes are ignored and upper data bits are dropped for narrow registers.
  assign unused_bits = ^{Addr[1:0], DataIn};

  always_comb begin
    presc_d = presc_q;
    pcnt_d  = tick ? '0 : pcnt_q + PRESC_W'(1);
    if (wr_en && presc_sel) begin
      presc_d = DataIn[PRESC_W-1:0];
      pcnt_d  = '0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             en_q, en_d, mode_q, mode_d, ie_q, ie_d, pend_q, pend_d;
    logic [WIDTH-1:0] load_q, load_d, count_q, count_d;
    logic             wr_ctrl, wr_load, wr_count, w1c, fire;

    assign ch_sel[g] = (Addr[11:8] == 4'h0) && (Addr[7:4] == 4'(g));
    assign wr_ctrl   = wr_en && ch_sel[g] && (Addr[3:2] == 2'd0);
    assign wr_load   = wr_en && ch_sel[g] && (Addr[3:2] == 2'd1);
    assign wr_count  = wr_en && ch_sel[g] && (Addr[3:2] == 2'd2);
    assign w1c       = wr_en && ((ch_sel[g] && (Addr[3:2] == 2'd3) && DataIn[0]) ||
                                 (irq_sel && DataIn[g]));
    // A bus write to COUNT pre-empts both the decrement and the expiry on that tick.
    assign fire      = tick && en_q && !wr_count;

    always_comb begin
      en_d    = en_q;
      mode_d  = mode_q;
      ie_d    = ie_q;
      pend_d  = pend_q;
      load_d  = load_q;
      count_d = count_q;
      if (w1c) pend_d = 1'b0;
      if (fire) begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          pend_d = 1'b1;
          if (mode_q) count_d = load_q;
          else        en_d    = 1'b0;
        end
      end
      if (wr_ctrl) begin
        en_d   = DataIn[0];
        mode_d = DataIn[1];
        ie_d   = DataIn[2];
        if (DataIn[0] && !en_q) count_d = load_q;
      end
      if (wr_load)  load_d  = DataIn[WIDTH-1:0];
      if (wr_count) count_d = DataIn[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        en_q    <= 1'b0;
        mode_q  <= 1'b0;
        ie_q    <= 1'b0;
        pend_q  <= 1'b0;
        load_q  <= '0;
        count_q <= '0;
      end else begin
        en_q    <= en_d;
        mode_q  <= mode_d;
        ie_q    <= ie_d;
        pend_q  <= pend_d;
        load_q  <= load_d;
        count_q <= count_d;
      end
    end

    assign en_v[g]    = en_q;
    assign mode_v[g]  = mode_q;
    assign ie_v[g]    = ie_q;
    assign pend_v[g]  = pend_q;
    assign load_v[g]  = load_q;
    assign count_v[g] = count_q;
  end

  always_comb begin
    rdata = '0;
    if (presc_sel) begin
      rdata[PRESC_W-1:0] = presc_q;
    end else if (irq_sel) begin
      rdata[NUM_CH-1:0] = pend_v;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel[i]) begin
          case (Addr[3:2])
            2'd0:    rdata[2:0]       = {ie_v[i], mode_v[i], en_v[i]};
            2'd1:    rdata[WIDTH-1:0] = load_v[i];
            2'd2:    rdata[WIDTH-1:0] = count_v[i];
            default: rdata[1:0]       = {en_v[i], pend_v[i]};
          endcase
        end
      end
    end
  end

  assign DataOut = (!CS_N && !RD_N) ? rdata : 32'h0;

  always_comb begin
    intr_vec_d = pend_v & ie_v;
    intr_d     = |(pend_v & ie_v);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      pcnt_q     <= '0;
      intr_vec_q <= '0;
      intr_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      intr_vec_q <= intr_vec_d;
      intr_q     <= intr_d;
    end
  end

  assign Intr     = intr_q;
  assign Intr_vec = intr_vec_q;

endmodule

// File: tb/tb_timer_counter_mc.sv
// Self-checking bench for timer_counter_mc (3 channels, 8-bit counters, 8-bit prescaler).
// Directed scenarios use hand-derived timing; the random phase is checked against a behavioural model.
`timescale 1ns/1ps
module tb_timer_counter_mc;
  localparam int N_CH  = 3;
  localparam int W     = 8;
  localparam int PW    = 8;
  localparam int unsigned WMASK = (1 << W) - 1;
  localparam int unsigned PMASK = (1 << PW) - 1;

  logic            clk;
  logic            reset;
  logic            CS_N, RD_N, WR_N;
  logic [11:0]     Addr;
  logic [31:0]     DataIn;
  logic [31:0]     DataOut;
  logic            Intr;
  logic [N_CH-1:0] Intr_vec;

  int checks   = 0;
  int failures = 0;

  timer_counter_mc #(.NUM_CH(N_CH), .WIDTH(W), .PRESC_W(PW)) dut (
    .clk(clk), .reset(reset), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
    .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut), .Intr(Intr), .Intr_vec(Intr_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents as plain numbers, updated once per clock edge.
  int unsigned     m_presc, m_pcnt;
  int unsigned     m_load [N_CH];
  int unsigned     m_count[N_CH];
  bit              m_en[N_CH], m_mode[N_CH], m_ie[N_CH], m_pend[N_CH];
  bit              m_intr;
  bit [N_CH-1:0]   m_vec;

  always @(posedge clk or posedge reset) begin : ref_model
    if (reset) begin
      m_presc = 0; m_pcnt = 0; m_intr = 0; m_vec = '0;
      for (int i = 0; i < N_CH; i++) begin
        m_load[i] = 0; m_count[i] = 0; m_en[i] = 0; m_mode[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
      end
    end else begin
      bit wr, tk, hit, was_en, fired;
      int region, ch, rg;
      wr     = (CS_N == 1'b0) && (WR_N == 1'b0);
      region = int'(Addr) / 256;
      ch     = (int'(Addr) % 256) / 16;
      rg     = (int'(Addr) % 16) / 4;
      tk     = (m_pcnt == m_presc);
      m_intr = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_vec[i] = m_pend[i] && m_ie[i];
        m_intr   = m_intr || m_vec[i];
      end
      if (wr && Addr == 12'h100) begin
        m_presc = DataIn & PMASK;
        m_pcnt  = 0;
      end else begin
        m_pcnt = tk ? 0 : m_pcnt + 1;
      end
      for (int i = 0; i < N_CH; i++) begin
        hit    = wr && region == 0 && ch == i;
        was_en = m_en[i];
        fired  = 0;
        if (tk && was_en && !(hit && rg == 2)) begin
          if (m_count[i] != 0) m_count[i] = m_count[i] - 1;
          else begin
            fired = 1;
            if (m_mode[i]) m_count[i] = m_load[i];
            else           m_en[i] = 0;
          end
        end
        if (hit && rg == 0) begin
          m_en[i] = DataIn[0]; m_mode[i] = DataIn[1]; m_ie[i] = DataIn[2];
          if (DataIn[0] && !was_en) m_count[i] = m_load[i];
        end
        if (hit && rg == 1) m_load[i]  = DataIn & WMASK;
        if (hit && rg == 2) m_count[i] = DataIn & WMASK;
        if ((hit && rg == 3 && DataIn[0]) || (wr && Addr == 12'h104 && DataIn[i])) m_pend[i] = 0;
        if (fired) m_pend[i] = 1;
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] v;
    int region, ch, rg;
    v      = '0;
    region = int'(a) / 256;
    ch     = (int'(a) % 256) / 16;
    rg     = (int'(a) % 16) / 4;
    if (a == 12'h100) v = m_presc;
    else if (a == 12'h104) begin
      for (int i = 0; i < N_CH; i++) v[i] = m_pend[i];
    end else if (region == 0 && ch < N_CH) begin
      case (rg)
        0:       v = {29'b0, m_ie[ch], m_mode[ch], m_en[ch]};
        1:       v = m_load[ch];
        2:       v = m_count[ch];
        default: v = {30'b0, m_en[ch], m_pend[ch]};
      endcase
    end
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1; Addr = '0; DataIn = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    Addr = a; DataIn = d; CS_N = 1'b0; WR_N = 1'b0;
    @(negedge clk);
    CS_N = 1'b1; WR_N = 1'b1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    Addr = a; CS_N = 1'b0; RD_N = 1'b0;
    #1 d = DataOut;
    CS_N = 1'b1; RD_N = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    logic [11:0] a;
    do_reset();
    for (int i = 0; i < N_CH * 4 + 3; i++) begin
      if (i < N_CH * 4) a = 12'(i * 4);
      else if (i == N_CH * 4) a = 12'h100;
      else if (i == N_CH * 4 + 1) a = 12'h104;
      else a = 12'h1F0;
      rd(a, got);
      checks++;
      if (got !== 32'h0) begin failures++; $display("FAIL reset_read addr=%03h got=%08h exp=0", a, got); end
    end
    checks++;
    if (Intr !== 1'b0 || Intr_vec !== '0) begin
      failures++; $display("FAIL reset_intr got=%b/%b exp=0/0", Intr, Intr_vec);
    end
  endtask

  task automatic test_oneshot();
    int first_pend = -1, first_intr = -1;
    logic [31:0] s;
    do_reset();
    wr(12'h004, 4);
    wr(12'h100, 3);
    idle(3);            // CTRL edge lands four cycles after the prescaler restart
    wr(12'h000, 5);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      rd(12'h00C, s);
      if (s[0] && first_pend < 0) first_pend = k;
      if (Intr === 1'b1 && first_intr < 0) first_intr = k;
    end
    checks++;
    if (first_pend != 20) begin failures++; $display("FAIL oneshot_pend_cycle got=%0d exp=20", first_pend); end
    checks++;
    if (first_intr != 21) begin failures++; $display("FAIL oneshot_intr_cycle got=%0d exp=21", first_intr); end
    rd(12'h000, s);
    checks++;
    if (s !== 32'h4) begin failures++; $display("FAIL oneshot_ctrl got=%08h exp=00000004", s); end
    rd(12'h008, s);
    checks++;
    if (s !== 32'h0) begin failures++; $display("FAIL oneshot_count got=%08h exp=0", s); end
    checks++;
    if (Intr_vec !== 3'b001) begin failures++; $display("FAIL oneshot_vec got=%b exp=001", Intr_vec); end
  endtask

  task automatic test_periodic();
    logic [31:0] c, s, exp_c, exp_s;
    do_reset();
    wr(12'h100, 0);
    wr(12'h014, 2);
    wr(12'h010, 3);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      rd(12'h018, c);
      rd(12'h01C, s);
      exp_c = 32'(2 - (k % 3));
      exp_s = (k >= 3) ? 32'h3 : 32'h2;
      checks++;
      if (c !== exp_c) begin failures++; $display("FAIL periodic_count k=%0d got=%0d exp=%0d", k, c, exp_c); end
      checks++;
      if (s !== exp_s) begin failures++; $display("FAIL periodic_status k=%0d got=%0h exp=%0h", k, s, exp_s); end
    end
  endtask

  task automatic test_irq_w1c();
    logic [31:0] s;
    do_reset();
    wr(12'h100, 0);
    wr(12'h004, 3);
    wr(12'h000, 7);     // expiries at 4 and 8 edges after this write
    idle(5);
    rd(12'h00C, s);
    checks++;
    if (s !== 32'h3 || Intr !== 1'b1) begin failures++; $display("FAIL irq_pending got=%0h/%b exp=3/1", s, Intr); end
    wr(12'h104, 1);
    rd(12'h00C, s);
    checks++;
    if (s !== 32'h2 || Intr !== 1'b1) begin failures++; $display("FAIL irq_cleared got=%0h/%b exp=2/1", s, Intr); end
    idle(1);
    checks++;
    if (Intr !== 1'b0) begin failures++; $display("FAIL irq_intr_fall got=%b exp=0", Intr); end
    wr(12'h104, 1);     // coincides with the second expiry
    rd(12'h00C, s);
    checks++;
    if (s !== 32'h3) begin failures++; $display("FAIL irq_set_wins got=%0h exp=3", s); end
    wr(12'h00C, 1);
    rd(12'h00C, s);
    checks++;
    if (s !== 32'h2 || Intr !== 1'b1) begin failures++; $display("FAIL status_w1c got=%0h/%b exp=2/1", s, Intr); end
  endtask

  task automatic test_count_write();
    logic [31:0] c;
    do_reset();
    wr(12'h024, 5);
    wr(12'h100, 3);
    idle(3);
    wr(12'h020, 1);     // ticks now land 4, 8, 12... edges later
    idle(3);
    rd(12'h028, c);
    checks++;
    if (c !== 32'd5) begin failures++; $display("FAIL cw_before got=%0d exp=5", c); end
    wr(12'h028, 100);   // same edge as a tick
    rd(12'h028, c);
    checks++;
    if (c !== 32'd100) begin failures++; $display("FAIL cw_write_wins got=%0d exp=100", c); end
    idle(3);
    rd(12'h028, c);
    checks++;
    if (c !== 32'd100) begin failures++; $display("FAIL cw_hold got=%0d exp=100", c); end
    idle(1);
    rd(12'h028, c);
    checks++;
    if (c !== 32'd99) begin failures++; $display("FAIL cw_decrement got=%0d exp=99", c); end
    wr(12'h020, 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      rd(12'h028, c);
      checks++;
      if (c !== 32'd99) begin failures++; $display("FAIL cw_frozen k=%0d got=%0d exp=99", k, c); end
    end
    wr(12'h020, 1);
    rd(12'h028, c);
    checks++;
    if (c !== 32'd5) begin failures++; $display("FAIL cw_reload got=%0d exp=5", c); end
  endtask

  task automatic test_width_unmapped();
    logic [31:0] got;
    do_reset();
    wr(12'h004, 32'h1FF);
    rd(12'h004, got);
    checks++;
    if (got !== 32'hFF) begin failures++; $display("FAIL width_load got=%08h exp=000000ff", got); end
    wr(12'h100, 32'h1FF);
    rd(12'h100, got);
    checks++;
    if (got !== 32'hFF) begin failures++; $display("FAIL width_presc got=%08h exp=000000ff", got); end
    wr(12'h030, 7);
    wr(12'h034, 32'h55);
    wr(12'h038, 9);
    wr(12'h1F0, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      logic [11:0] a;
      a = (i < 4) ? 12'(12'h030 + i * 4) : 12'h1F0;
      rd(a, got);
      checks++;
      if (got !== 32'h0) begin failures++; $display("FAIL unmapped addr=%03h got=%08h exp=0", a, got); end
    end
    rd(12'h000, got);
    checks++;
    if (got !== 32'h0) begin failures++; $display("FAIL unmapped_alias got=%08h exp=0", got); end
    Addr = 12'h004; CS_N = 1'b0; RD_N = 1'b1;
    #1;
    checks++;
    if (DataOut !== 32'h0) begin failures++; $display("FAIL read_gate got=%08h exp=0", DataOut); end
    CS_N = 1'b1; WR_N = 1'b0; DataIn = 32'h12;
    @(negedge clk);
    WR_N = 1'b1;
    rd(12'h004, got);
    checks++;
    if (got !== 32'hFF) begin failures++; $display("FAIL write_gate got=%08h exp=000000ff", got); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] got;
    do_reset();
    wr(12'h100, 0);
    wr(12'h004, 5);
    wr(12'h000, 7);
    idle(12);
    checks++;
    if (Intr !== 1'b1) begin failures++; $display("FAIL rst_pre_intr got=%b exp=1", Intr); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (Intr !== 1'b0 || Intr_vec !== '0) begin
      failures++; $display("FAIL rst_async_intr got=%b/%b exp=0/0", Intr, Intr_vec);
    end
    rd(12'h008, got);
    checks++;
    if (got !== 32'h0) begin failures++; $display("FAIL rst_async_count got=%08h exp=0", got); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd(12'h000, got);
    checks++;
    if (got !== 32'h0) begin failures++; $display("FAIL rst_ctrl got=%08h exp=0", got); end
  endtask

  function automatic logic [11:0] rand_addr();
    int pick;
    pick = $urandom_range(0, 18);
    if (pick < 16) return {4'h0, 4'(pick / 4), 2'(pick % 4), 2'b00};
    if (pick == 16) return 12'h100;
    if (pick == 17) return 12'h104;
    return 12'h1F0;
  endfunction

  function automatic logic [31:0] rand_data(input logic [11:0] a);
    if (a == 12'h100) return $urandom_range(0, 3);
    if (a == 12'h104) return $urandom;
    if (a[3:2] == 2'd0) return $urandom_range(0, 7);
    if (a[3:2] == 2'd3) return $urandom_range(0, 1);
    if ($urandom_range(0, 9) == 0) return 32'h1FF;
    return $urandom_range(0, 12);
  endfunction

  task automatic test_random();
    logic [11:0] a;
    logic [31:0] got, exp;
    do_reset();
    for (int it = 0; it < 800; it++) begin
      a = rand_addr();
      rd(a, got);
      exp = model_read(a);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL rand_read it=%0d addr=%03h got=%08h exp=%08h", it, a, got, exp); end
      checks++;
      if (Intr !== m_intr || Intr_vec !== m_vec) begin
        failures++; $display("FAIL rand_intr it=%0d got=%b/%b exp=%b/%b", it, Intr, Intr_vec, m_intr, m_vec);
      end
      if ($urandom_range(0, 2) == 0) begin
        a = rand_addr();
        Addr = a; DataIn = rand_data(a);
        CS_N = ($urandom_range(0, 7) == 0); WR_N = 1'b0;
      end
      @(negedge clk);
      CS_N = 1'b1; WR_N = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1; Addr = '0; DataIn = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_irq_w1c();
    test_count_write();
    test_width_unmapped();
    test_reset_midcount();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
